// File: rtl/axi_read_responder.sv
// AXI4 read-only slave over a 64-bit backing memory, plus an AC snoop master
// that queues one MakeInvalid per accepted backing-store write.
module axi_read_responder #(
  parameter int ID_WIDTH         = 13,
  parameter int ADDR_WIDTH       = 64,
  parameter int DATA_WIDTH       = 64,
  parameter int LOG_DEPTH        = 12,
  parameter int LATENCY          = 4,
  parameter int LINE_BYTES       = 64,
  parameter int SNOOP_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  m_axi_acvalid,
  input  logic                  m_axi_acready,
  output logic [ADDR_WIDTH-1:0] m_axi_acaddr,
  output logic [3:0]            m_axi_acsnoop,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PTR_W  = (SNOOP_FIFO_DEPTH > 1) ? $clog2(SNOOP_FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(SNOOP_FIFO_DEPTH + 1);
  localparam int DEPTH  = 1 << LOG_DEPTH;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic [2:0]            size_q;
  logic [7:0]            beat_q;
  logic                  rvalid_q, rlast_q;
  logic [1:0]            rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  ar_hs, r_hs, load_beat, wrap_ok, size_err, dec_err;
  logic [7:0]            next_beat;
  logic [ADDR_WIDTH-1:0] base_addr, incr_addr, wrap_mask, beat_addr;
  logic [1:0]            beat_resp;
  logic [DATA_WIDTH-1:0] beat_data;

  // Valid/ready: a transfer happens on any edge where valid && ready; the
  // source holds valid and payload stable until that edge.
  assign s_axi_arready = (state_q == ST_IDLE);
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign r_hs          = rvalid_q && s_axi_rready;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (ar_hs) begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(LATENCY - 1);
      end
      ST_WAIT: if (cnt_q == '0) state_d = ST_DATA;
               else cnt_d = cnt_q - CNT_W'(1);
      ST_DATA: if (r_hs && rlast_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The next beat is presented either on leaving WAIT or on a non-final handshake.
  assign load_beat = ((state_q == ST_WAIT) && (cnt_q == '0)) || (r_hs && !rlast_q);
  assign next_beat = (state_q == ST_DATA) ? beat_q + 8'd1 : 8'd0;

  always_comb begin
    base_addr = addr_q & ~ADDR_WIDTH'(7);
    incr_addr = base_addr + {{(ADDR_WIDTH-11){1'b0}}, next_beat, 3'b000};
    wrap_mask = {{(ADDR_WIDTH-11){1'b0}}, len_q, 3'b111};
    wrap_ok   = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    size_err  = (size_q != 3'h3);
    case (burst_q)
      2'd0:    beat_addr = base_addr;
      2'd2:    beat_addr = wrap_ok ? ((base_addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                   : incr_addr;
      default: beat_addr = incr_addr;
    endcase
    dec_err   = (beat_addr >> (LOG_DEPTH + 3)) != '0;
    beat_data = mem_q[beat_addr[LOG_DEPTH+2:3]];
    beat_resp = RESP_OKAY;
    if (size_err) begin
      beat_resp = RESP_SLVERR;
      beat_data = '0;
    end else if (dec_err) begin
      beat_resp = RESP_DECERR;
      beat_data = '0;
    end else if ((burst_q == 2'd2) && !wrap_ok) begin
      beat_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      burst_q  <= '0;
      size_q   <= '0;
      beat_q   <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ar_hs) begin
        id_q    <= s_axi_arid;
        addr_q  <= s_axi_araddr;
        len_q   <= s_axi_arlen;
        burst_q <= s_axi_arburst;
        size_q  <= s_axi_arsize;
      end
      if (load_beat) begin
        beat_q   <= next_beat;
        rvalid_q <= 1'b1;
        rlast_q  <= (next_beat == len_q);
        rresp_q  <= beat_resp;
        rid_q    <= id_q;
        rdata_q  <= beat_data;
      end else if (r_hs && rlast_q) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  // Snoop FIFO: one line-aligned MakeInvalid per accepted write, no merging.
  logic [ADDR_WIDTH-1:0] fifo_q [SNOOP_FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [FCNT_W-1:0]     fcnt_q;
  logic                  fifo_empty, fifo_full, push, pop, mem_wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SNOOP_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty    = (fcnt_q == '0);
  assign fifo_full     = (fcnt_q == FCNT_W'(SNOOP_FIFO_DEPTH));
  assign m_axi_acvalid = !fifo_empty;
  assign m_axi_acaddr  = fifo_empty ? '0 : fifo_q[rd_ptr_q];
  assign m_axi_acsnoop = 4'hd;
  assign pop           = m_axi_acvalid && m_axi_acready;
  assign mem_wready    = !fifo_full || pop;
  assign push          = mem_we && mem_wready;
  assign mem_wr        = push && ((mem_waddr >> (LOG_DEPTH + 3)) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_waddr & LINE_MASK;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + FCNT_W'(1);
        2'b01:   fcnt_q <= fcnt_q - FCNT_W'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // Backing store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[mem_waddr[LOG_DEPTH+2:3]] <= mem_wdata;
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: table-driven bursts plus hand-written
// stall, write-during-beat, snoop back-pressure and reset sequences.
module tb_axi_read_responder;

  localparam int LATENCY = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] s_axi_arid = '0;
  logic [63:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'h3;
  logic [1:0]  s_axi_arburst = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [12:0] s_axi_rid;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        m_axi_acvalid;
  logic        m_axi_acready = 1'b1;
  logic [63:0] m_axi_acaddr;
  logic [3:0]  m_axi_acsnoop;
  logic        mem_we = 1'b0;
  logic [63:0] mem_waddr = '0;
  logic [63:0] mem_wdata = '0;
  logic        mem_wready;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [63:0]        addr;
    logic [7:0]         len;
    logic [1:0]         burst;
    logic [2:0]         size;
    logic [12:0]        id;
    logic [0:7][63:0]   data;
    logic [0:7][1:0]    resp;
  } burst_vec_t;

  localparam int NVEC = 10;
  burst_vec_t vecs[NVEC];

  axi_read_responder #(.LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_acvalid(m_axi_acvalid), .m_axi_acready(m_axi_acready),
    .m_axi_acaddr(m_axi_acaddr), .m_axi_acsnoop(m_axi_acsnoop),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wready(mem_wready)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [63:0] a, input logic [7:0] l,
                         input logic [1:0] b, input logic [2:0] s,
                         input logic [511:0] d, input logic [15:0] r);
    vecs[i].addr  = a;
    vecs[i].len   = l;
    vecs[i].burst = b;
    vecs[i].size  = s;
    vecs[i].id    = 13'(i + 'h0A0);
    vecs[i].data  = d;
    vecs[i].resp  = r;
  endtask

  // Driver tasks
  task automatic mem_write(input logic [63:0] a, input logic [63:0] d);
    int g;
    mem_we = 1'b1;
    mem_waddr = a;
    mem_wdata = d;
    #1;
    g = 0;
    while (!mem_wready && g < 50) begin
      tick;
      g++;
    end
    if (g >= 50) check("wready_timeout", 64'd0, 64'd1);
    tick;
    mem_we = 1'b0;
  endtask

  task automatic drive_ar(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b,
                          input logic [2:0] s, input logic [12:0] id);
    s_axi_araddr  = a;
    s_axi_arlen   = l;
    s_axi_arburst = b;
    s_axi_arsize  = s;
    s_axi_arid    = id;
    s_axi_arvalid = 1'b1;
    #1;
    check("arready_idle", 64'(s_axi_arready), 64'd1);
    tick;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_rvalid;
    int cyc;
    cyc = 0;
    while (!s_axi_rvalid && cyc < 100) begin
      tick;
      cyc++;
    end
    check("first_rvalid_latency", 64'(cyc), 64'(LATENCY));
  endtask

  task automatic run_burst(input burst_vec_t v, input bit stall);
    int beat, guard, hold;
    logic rv;
    drive_ar(v.addr, v.len, v.burst, v.size, v.id);
    wait_rvalid();
    beat = 0;
    guard = 0;
    hold = 0;
    while (beat <= int'(v.len) && guard < 400) begin
      rv = s_axi_rvalid;
      if (rv) begin
        check($sformatf("rdata a=%0h b=%0d", v.addr, beat), s_axi_rdata, v.data[beat]);
        check($sformatf("rresp a=%0h b=%0d", v.addr, beat), 64'(s_axi_rresp), 64'(v.resp[beat]));
        check($sformatf("rid a=%0h b=%0d", v.addr, beat), 64'(s_axi_rid), 64'(v.id));
        check($sformatf("rlast a=%0h b=%0d", v.addr, beat), 64'(s_axi_rlast),
              64'(beat == int'(v.len)));
        check("arready_busy", 64'(s_axi_arready), 64'd0);
      end else begin
        check("rvalid_gap", 64'd0, 64'd1);
      end
      if (stall && beat == 2 && hold < 5) begin
        s_axi_rready = 1'b0;
        hold++;
      end else if (stall) begin
        s_axi_rready = 1'($urandom_range(0, 1));
      end else begin
        s_axi_rready = 1'b1;
      end
      tick;
      if (rv && s_axi_rready) beat++;
      guard++;
    end
    if (guard >= 400) check("burst_timeout", 64'(beat), 64'(v.len) + 64'd1);
    s_axi_rready = 1'b0;
    check("rvalid_after_last", 64'(s_axi_rvalid), 64'd0);
    check("arready_after_last", 64'(s_axi_arready), 64'd1);
  endtask

  task automatic check_reset_idle(input string tag);
    int seen;
    check({tag, "_rvalid"}, 64'(s_axi_rvalid), 64'd0);
    check({tag, "_arready"}, 64'(s_axi_arready), 64'd1);
    seen = 0;
    repeat (8) begin
      tick;
      if (s_axi_rvalid) seen++;
    end
    check({tag, "_no_beats"}, 64'(seen), 64'd0);
  endtask

  burst_vec_t vr, vw;

  initial begin
    // Expected bursts against preload word i = 0x1000+i, word 4095 = 0xCAFE0FFF
    set_vec(0, 64'h18, 8'd7, 2'd2, 3'h3,
      {64'h1003, 64'h1004, 64'h1005, 64'h1006, 64'h1007, 64'h1000, 64'h1001, 64'h1002},
      {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
    set_vec(1, 64'h28, 8'd3, 2'd1, 3'h3,
      {64'h1005, 64'h1006, 64'h1007, 64'h1008, 64'h0, 64'h0, 64'h0, 64'h0}, 16'h0);
    set_vec(2, 64'h08, 8'd2, 2'd0, 3'h3,
      {64'h1001, 64'h1001, 64'h1001, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0}, 16'h0);
    set_vec(3, 64'h38, 8'd0, 2'd1, 3'h3,
      {64'h1007, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0}, 16'h0);
    set_vec(4, 64'h10, 8'd2, 2'd2, 3'h3,
      {64'h1002, 64'h1003, 64'h1004, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0},
      {2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
    set_vec(5, 64'h28, 8'd3, 2'd2, 3'h3,
      {64'h1005, 64'h1006, 64'h1007, 64'h1004, 64'h0, 64'h0, 64'h0, 64'h0}, 16'h0);
    set_vec(6, 64'h8000, 8'd1, 2'd1, 3'h3, 512'h0,
      {2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
    set_vec(7, 64'h7FF8, 8'd1, 2'd1, 3'h3,
      {64'hCAFE0FFF, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0},
      {2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
    set_vec(8, 64'h20, 8'd1, 2'd1, 3'h2, 512'h0,
      {2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
    set_vec(9, 64'h38, 8'd1, 2'd2, 3'h3,
      {64'h1007, 64'h1006, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0}, 16'h0);

    // Reset values
    repeat (3) tick;
    reset = 1'b0;
    check("rst_arready", 64'(s_axi_arready), 64'd1);
    check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_rlast", 64'(s_axi_rlast), 64'd0);
    check("rst_rresp", 64'(s_axi_rresp), 64'd0);
    check("rst_rid", 64'(s_axi_rid), 64'd0);
    check("rst_rdata", s_axi_rdata, 64'd0);
    check("rst_acvalid", 64'(m_axi_acvalid), 64'd0);
    check("rst_acaddr", m_axi_acaddr, 64'd0);
    check("rst_acsnoop", 64'(m_axi_acsnoop), 64'hd);
    check("rst_wready", 64'(mem_wready), 64'd1);

    for (int i = 0; i < 16; i++) mem_write(64'(i * 8), 64'h1000 + 64'(i));
    mem_write(64'h7FF8, 64'hCAFE0FFF);
    repeat (2) tick;

    for (int i = 0; i < NVEC; i++) run_burst(vecs[i], 1'b0);
    run_burst(vecs[0], 1'b1);
    run_burst(vecs[1], 1'b1);

    // Write during a held beat: held beat unchanged, later beat sees new data
    drive_ar(64'h60, 8'd1, 2'd1, 3'h3, 13'h155);
    wait_rvalid();
    check("held_beat0", s_axi_rdata, 64'h100C);
    mem_write(64'h60, 64'hDEAD);
    check("held_beat0_after_wr", s_axi_rdata, 64'h100C);
    mem_write(64'h68, 64'hBEEF);
    check("held_beat0_rvalid", 64'(s_axi_rvalid), 64'd1);
    s_axi_rready = 1'b1;
    tick;
    check("beat1_new_data", s_axi_rdata, 64'hBEEF);
    check("beat1_rlast", 64'(s_axi_rlast), 64'd1);
    tick;
    s_axi_rready = 1'b0;
    check("wr_burst_done", 64'(s_axi_rvalid), 64'd0);
    vw.addr = 64'h60; vw.len = 8'd0; vw.burst = 2'd1; vw.size = 3'h3; vw.id = 13'h1FFF;
    vw.data = {64'hDEAD, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    vw.resp = 16'h0;
    run_burst(vw, 1'b0);

    // Snoop back-pressure: four writes fill the FIFO, fifth waits
    repeat (2) tick;
    m_axi_acready = 1'b0;
    tick;
    check("snoop_idle_acvalid", 64'(m_axi_acvalid), 64'd0);
    exp_q.push_back(64'h40);
    exp_q.push_back(64'h40);
    exp_q.push_back(64'h80);
    exp_q.push_back(64'hC0);
    exp_q.push_back(64'h100);
    begin
      logic [63:0] wa[4];
      wa[0] = 64'h40; wa[1] = 64'h48; wa[2] = 64'h80; wa[3] = 64'hC0;
      for (int i = 0; i < 4; i++) begin
        mem_we = 1'b1;
        mem_waddr = wa[i];
        mem_wdata = 64'hA000 + 64'(i);
        #1;
        check($sformatf("wready_w%0d", i), 64'(mem_wready), 64'd1);
        tick;
      end
    end
    mem_waddr = 64'h100;
    mem_wdata = 64'hA004;
    #1;
    check("wready_full", 64'(mem_wready), 64'd0);
    tick;
    check("wready_full_hold", 64'(mem_wready), 64'd0);
    check("acaddr_head_stalled", m_axi_acaddr, 64'h40);
    m_axi_acready = 1'b1;
    #1;
    check("wready_full_pop", 64'(mem_wready), 64'd1);
    begin
      int g;
      g = 0;
      while (m_axi_acvalid && g < 20) begin
        if (exp_q.size() > 0) check($sformatf("acaddr_%0d", g), m_axi_acaddr, exp_q.pop_front());
        else check("acaddr_extra", m_axi_acaddr, 64'hFFFF_FFFF_FFFF_FFFF);
        check("acsnoop", 64'(m_axi_acsnoop), 64'hd);
        tick;
        mem_we = 1'b0;
        g++;
      end
      mem_we = 1'b0;
    end
    check("snoop_all_seen", 64'(exp_q.size()), 64'd0);
    check("snoop_drained", 64'(m_axi_acvalid), 64'd0);

    // Reset during WAIT, then during third beat of DATA
    vr.addr = 64'h10; vr.len = 8'd3; vr.burst = 2'd1; vr.size = 3'h3; vr.id = 13'h0777;
    vr.data = {64'h1002, 64'h1003, 64'h1004, 64'h1005, 64'h0, 64'h0, 64'h0, 64'h0};
    vr.resp = 16'h0;
    drive_ar(vr.addr, vr.len, vr.burst, vr.size, vr.id);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_reset_idle("rst_wait");
    run_burst(vr, 1'b0);

    drive_ar(vr.addr, vr.len, vr.burst, vr.size, vr.id);
    wait_rvalid();
    s_axi_rready = 1'b1;
    tick;
    tick;
    s_axi_rready = 1'b0;
    check("beat3_before_reset", s_axi_rdata, 64'h1004);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_reset_idle("rst_data");
    run_burst(vr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
